// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and the word memory (slave).
// The fetch unit presents a byte address; the memory answers with the word in the same cycle.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a zero-latency word memory and
// fills the IF/ID register. Handles redirects, hazard stalls, halt and out-of-range fetches.
// Optional macro FETCH_PERF_EN adds saturating fetch/flush performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int          IMEM_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   imem,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  input  logic                 halt,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic                 oor_err,
  output logic [1:0]           fetch_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed
`endif
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ip4_q, ip4_d;
  logic        valid_q, valid_d;
  logic        oor_q, oor_d;
  logic        out_of_range;

  assign imem.imem_addr = pc_q;
  assign out_of_range   = (pc_q >= IMEM_BYTES);

  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ip4_q;
  assign if_id_valid    = valid_q;
  assign oor_err        = oor_q;
  assign fetch_state    = state_q;

  // State register and IF/ID pipeline register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      ip4_q   <= 32'd0;
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ip4_q   <= ip4_d;
      valid_q <= valid_d;
      oor_q   <= oor_d;
    end
  end

  // Next-state and next-datapath logic; in RUN: redirect > stall > halt/range > normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ip4_d   = ip4_q;
    valid_d = valid_q;
    oor_d   = oor_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d    = redirect_target & ~32'd3;
          valid_d = 1'b0;
          instr_d = 32'd0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt || out_of_range) begin
          state_d = HALTED;
          valid_d = 1'b0;
          if (out_of_range) begin
            oor_d = 1'b1;
          end
        end else begin
          pc_d    = pc_q + PC_STEP;
          instr_d = imem.imem_instr;
          ipc_d   = pc_q;
          ip4_d   = pc_q + PC_STEP;
          valid_d = 1'b1;
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = HALTED;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;
  logic        fetch_evt;
  logic        flush_evt;

  assign fetch_evt    = (state_q == RUN) && !redirect && !stall && !halt && !out_of_range;
  assign flush_evt    = (state_q == RUN) && redirect && valid_q;
  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;

  // Saturating counters of completed fetches and of valid instructions flushed by redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      flushed_q <= 32'd0;
    end else begin
      if (fetch_evt && (fetched_q != 32'hFFFF_FFFF)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (flush_evt && (flushed_q != 32'hFFFF_FFFF)) begin
        flushed_q <= flushed_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the fetch stage.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        oor_err;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [16];

  instr_fetch_unit_if bus ();

  assign bus.imem_instr = mem[bus.imem_addr[5:2]];

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (bus),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .oor_err         (oor_err),
    .fetch_state     (fetch_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_flushed    (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ip4;
  logic        m_valid;
  logic        m_oor;
  int          m_phase;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  task automatic modelEdge();
    logic stop;
    stop = 1'b0;
    if (!rst_n) begin
      m_pc      = 32'd0;
      m_instr   = 32'd0;
      m_ipc     = 32'd0;
      m_ip4     = 32'd0;
      m_valid   = 1'b0;
      m_oor     = 1'b0;
      m_phase   = 0;
      m_fetched = 32'd0;
      m_flushed = 32'd0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (redirect) begin
        if (m_valid && m_flushed != 32'hFFFF_FFFF) m_flushed = m_flushed + 1;
        m_pc    = {redirect_target[31:2], 2'b00};
        m_valid = 1'b0;
        m_instr = 32'd0;
      end else if (!stall) begin
        if (m_pc >= 32'd64) begin
          m_oor = 1'b1;
          stop  = 1'b1;
        end
        if (halt) stop = 1'b1;
        if (stop) begin
          m_phase = 2;
          m_valid = 1'b0;
        end else begin
          m_instr = mem[m_pc / 4];
          m_ipc   = m_pc;
          m_ip4   = m_pc + 32'd4;
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b1;
          if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_ip4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("oor_err", {31'd0, oor_err}, {31'd0, m_oor});
    chk("fetch_state", {30'd0, fetch_state}, 32'(m_phase));
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] t, input logic h);
    rst_n           = r;
    stall           = s;
    redirect        = rd;
    redirect_target = t;
    halt            = h;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0; halt = 1'b0;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_oor = 0; m_phase = 0;
    m_fetched = 0; m_flushed = 0;

    // Reset while stall and redirect are asserted: reset must win
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
    chk("reset_addr", bus.imem_addr, 32'd0);

    // Boot bubble and three sequential fetches
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("boot_bubble", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("fourth_edge_addr", bus.imem_addr, 32'd12);
    chk("fourth_edge_pc", if_id_pc, 32'd8);

    // Stall for three cycles, then release
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall_hold_addr", bus.imem_addr, 32'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    // Redirect with stall: low address bits dropped, IF/ID flushed
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0023, 1'b0);
    chk("redirect_addr", bus.imem_addr, 32'h20);
    chk("redirect_flush", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("after_redirect_pc", if_id_pc, 32'h20);

    // Fetch the last word, then run off the end of memory
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd60, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("last_word_plus4", if_id_pc_plus4, 32'd64);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("oor_set", {31'd0, oor_err}, 32'd1);
    chk("oor_state", {30'd0, fetch_state}, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd4, 1'b0);

    // Halt at PC 16; redirect afterwards is ignored; reset recovers
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("pre_halt_addr", bus.imem_addr, 32'd16);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    chk("halted_addr", bus.imem_addr, 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rearm_state", {30'd0, fetch_state}, 32'd0);

    // Five fetches then a redirect with a valid IF/ID
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd8, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_flushed_1", perf_flushed, 32'd1);
`endif

    // Random phase
    for (int n = 0; n < 400; n++) begin
      logic        r, s, rd, h;
      logic [31:0] t;
      r  = ($urandom_range(0, 24) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 29) == 0);
      t  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 70));
      applyStimulus(r, s, rd, t, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
